// File: rtl/uart_rx_ctrl.sv
// UART receive-side sequencer: frame state machine, stop-bit check, per-frame status
// and saturating good/error frame counters.
module uart_rx_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             trigger_i,
  input  logic             rx_i,
  input  logic             rx_en_i,
  input  logic             parity_en_i,
  input  logic             crc_en_i,
  input  logic [4:0]       bit_cnt_i,
  input  logic             parity_ok_i,
  input  logic             crc_ok_i,
  input  logic             stat_clr_i,
  output logic             is_rx_idle_o,
  output logic             is_rx_data_o,
  output logic             is_rx_pairity_o,
  output logic             is_rx_crc_o,
  output logic             is_rx_stop_o,
  output logic             is_rx_break_o,
  output logic             changed_rx_state_o,
  output logic             crc_en_o,
  output logic             rx_done_o,
  output logic             frame_err_o,
  output logic             parity_err_o,
  output logic             crc_err_o,
  output logic [CNT_W-1:0] good_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  typedef enum logic [2:0] {
    StIdle,
    StData,
    StParity,
    StCrc,
    StStop,
    StBreak
  } state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic             par_q, crc_q;
  logic             rx_done_q;
  logic             frame_err_q, parity_err_q, crc_err_q;
  logic [CNT_W-1:0] good_cnt_q, err_cnt_q;
  logic             stop_done;
  logic             frame_good;

  always_comb begin
    state_d = state_q;
    if (trigger_i) begin
      unique case (state_q)
        StIdle:   if (!rx_i && rx_en_i) state_d = StData;
        StData: begin
          if (bit_cnt_i == 5'd7) begin
            if (par_q)      state_d = StParity;
            else if (crc_q) state_d = StCrc;
            else            state_d = StStop;
          end
        end
        StParity: state_d = crc_q ? StCrc : StStop;
        StCrc:    if (bit_cnt_i == 5'd7) state_d = StStop;
        StStop:   state_d = rx_i ? StIdle : StBreak;
        StBreak:  if (rx_i) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Reset overrides any pending transition, so no strobe is issued to the data path.
  assign changed_rx_state_o = ~rst_i & (state_d != state_q);
  assign stop_done          = trigger_i & (state_q == StStop);
  assign frame_good         = ~(frame_err_q | parity_err_q | crc_err_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      par_q        <= 1'b0;
      crc_q        <= 1'b0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      crc_err_q    <= 1'b0;
      good_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      rx_done_q <= stop_done;
      if (state_q == StIdle && state_d == StData) begin
        par_q <= parity_en_i;
        crc_q <= crc_en_i;
      end
      if (stop_done) begin
        frame_err_q  <= ~rx_i;
        parity_err_q <= par_q & ~parity_ok_i;
        crc_err_q    <= crc_q & ~crc_ok_i;
      end
      // Counting happens at the end of the rx_done cycle, using the flags just registered.
      if (stat_clr_i) begin
        good_cnt_q <= '0;
        err_cnt_q  <= '0;
      end else if (rx_done_q) begin
        if (frame_good) begin
          if (good_cnt_q != CntMax) good_cnt_q <= good_cnt_q + CntOne;
        end else begin
          if (err_cnt_q != CntMax) err_cnt_q <= err_cnt_q + CntOne;
        end
      end
    end
  end

  assign is_rx_idle_o    = (state_q == StIdle);
  assign is_rx_data_o    = (state_q == StData);
  assign is_rx_pairity_o = (state_q == StParity);
  assign is_rx_crc_o     = (state_q == StCrc);
  assign is_rx_stop_o    = (state_q == StStop);
  assign is_rx_break_o   = (state_q == StBreak);

  assign crc_en_o     = crc_q;
  assign rx_done_o    = rx_done_q;
  assign frame_err_o  = frame_err_q;
  assign parity_err_o = parity_err_q;
  assign crc_err_o    = crc_err_q;
  assign good_cnt_o   = good_cnt_q;
  assign err_cnt_o    = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl; the bench plays the data path and drives
// bit_cnt_i itself. Counters are built 2 bits wide so saturation is reachable.
module tb_uart_rx_ctrl;

  localparam int unsigned CNT_W = 2;

  localparam logic [5:0] SIdle   = 6'b100000;
  localparam logic [5:0] SData   = 6'b010000;
  localparam logic [5:0] SParity = 6'b001000;
  localparam logic [5:0] SCrc    = 6'b000100;
  localparam logic [5:0] SStop   = 6'b000010;
  localparam logic [5:0] SBreak  = 6'b000001;

  logic             clk_i = 1'b0;
  logic             rst_i, trigger_i, rx_i, rx_en_i, parity_en_i, crc_en_i;
  logic [4:0]       bit_cnt_i;
  logic             parity_ok_i, crc_ok_i, stat_clr_i;
  logic             is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o;
  logic             is_rx_stop_o, is_rx_break_o, changed_rx_state_o, crc_en_o, rx_done_o;
  logic             frame_err_o, parity_err_o, crc_err_o;
  logic [CNT_W-1:0] good_cnt_o, err_cnt_o;

  int n_checks  = 0;
  int n_errors  = 0;
  int trig_n    = 0;
  int done_seen = 0;

  uart_rx_ctrl #(.CNT_W(CNT_W)) u_dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .trigger_i          (trigger_i),
    .rx_i               (rx_i),
    .rx_en_i            (rx_en_i),
    .parity_en_i        (parity_en_i),
    .crc_en_i           (crc_en_i),
    .bit_cnt_i          (bit_cnt_i),
    .parity_ok_i        (parity_ok_i),
    .crc_ok_i           (crc_ok_i),
    .stat_clr_i         (stat_clr_i),
    .is_rx_idle_o       (is_rx_idle_o),
    .is_rx_data_o       (is_rx_data_o),
    .is_rx_pairity_o    (is_rx_pairity_o),
    .is_rx_crc_o        (is_rx_crc_o),
    .is_rx_stop_o       (is_rx_stop_o),
    .is_rx_break_o      (is_rx_break_o),
    .changed_rx_state_o (changed_rx_state_o),
    .crc_en_o           (crc_en_o),
    .rx_done_o          (rx_done_o),
    .frame_err_o        (frame_err_o),
    .parity_err_o       (parity_err_o),
    .crc_err_o          (crc_err_o),
    .good_cnt_o         (good_cnt_o),
    .err_cnt_o          (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) if (rx_done_o) done_seen <= done_seen + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, is_rx_idle_o, is_rx_data_o, is_rx_pairity_o, is_rx_crc_o,
                is_rx_stop_o, is_rx_break_o}, {26'd0, exp});
  endtask

  // One idle cycle carrying junk on rx_i/bit_cnt_i, then one trigger cycle.
  // Returns 1 time unit after the trigger edge.
  task automatic trig(input logic rx, input logic [4:0] bc, input logic exp_ch);
    @(negedge clk_i);
    trigger_i = 1'b0;
    rx_i      = ~rx;
    bit_cnt_i = 5'd7;
    @(negedge clk_i);
    trigger_i = 1'b1;
    rx_i      = rx;
    bit_cnt_i = bc;
    #1;
    check("changed", {31'd0, changed_rx_state_o}, {31'd0, exp_ch});
    @(posedge clk_i);
    #1;
    trigger_i = 1'b0;
    trig_n++;
  endtask

  task automatic frame(input logic [7:0] d, input logic par, input logic crc,
                       input logic stopb, input logic pok, input logic cok, input logic clr);
    int t0;
    parity_ok_i = ~pok;
    crc_ok_i    = ~cok;
    parity_en_i = par;
    crc_en_i    = crc;
    t0          = trig_n;
    trig(1'b0, 5'd0, 1'b1);
    check_state("start", SData);
    check("crc_en_start", {31'd0, crc_en_o}, {31'd0, crc});
    // Flip the configuration mid-frame; the latched copy must govern this frame.
    parity_en_i = ~par;
    crc_en_i    = ~crc;
    for (int i = 0; i < 8; i++) begin
      trig(d[i], 5'(i), i == 7);
      if (i < 7) check_state("data", SData);
    end
    if (par) begin
      check_state("parity", SParity);
      trig(^d, 5'd0, 1'b1);
    end
    if (crc) begin
      for (int i = 0; i < 8; i++) begin
        check_state("crc", SCrc);
        check("crc_en_mid", {31'd0, crc_en_o}, 32'd1);
        trig(d[i], 5'(i), i == 7);
      end
    end
    check_state("stop", SStop);
    parity_ok_i = pok;
    crc_ok_i    = cok;
    trig(stopb, 5'd0, 1'b1);
    check_state("after_stop", stopb ? SIdle : SBreak);
    check("rx_done", {31'd0, rx_done_o}, 32'd1);
    check("frame_err", {31'd0, frame_err_o}, {31'd0, ~stopb});
    check("parity_err", {31'd0, parity_err_o}, {31'd0, par & ~pok});
    check("crc_err", {31'd0, crc_err_o}, {31'd0, crc & ~cok});
    check("frame_len", 32'(trig_n - t0), 32'(10 + int'(par) + 8 * int'(crc)));
    stat_clr_i = clr;
    @(posedge clk_i);
    #1;
    stat_clr_i  = 1'b0;
    parity_en_i = 1'b0;
    crc_en_i    = 1'b0;
    check("rx_done_pulse", {31'd0, rx_done_o}, 32'd0);
  endtask

  task automatic check_cnt(input string tag, input int good, input int err, input int done);
    check({tag, "_good"}, 32'(good_cnt_o), 32'(good));
    check({tag, "_err"}, 32'(err_cnt_o), 32'(err));
    check({tag, "_done"}, 32'(done_seen), 32'(done));
  endtask

  initial begin
    rst_i = 1'b1; trigger_i = 1'b0; rx_i = 1'b1; rx_en_i = 1'b1;
    parity_en_i = 1'b0; crc_en_i = 1'b0; bit_cnt_i = 5'd0;
    parity_ok_i = 1'b1; crc_ok_i = 1'b1; stat_clr_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_state("reset_state", SIdle);
    check("reset_changed", {31'd0, changed_rx_state_o}, 32'd0);
    check("reset_flags", {28'd0, rx_done_o, frame_err_o, parity_err_o, crc_err_o}, 32'd0);
    check("reset_crc_en", {31'd0, crc_en_o}, 32'd0);
    rst_i = 1'b0;
    check_cnt("reset", 0, 0, 0);

    // 8N1 byte 0xA5
    frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("plain", 1, 0, 1);
    // Parity enabled, parity bad
    frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check_cnt("par_bad", 1, 1, 2);
    // CRC good, then CRC bad
    frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("crc_ok", 2, 1, 3);
    frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_cnt("crc_bad", 2, 2, 4);

    // Break: stop sampled low, line held low for 5 more triggers
    frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      trig(1'b0, 5'(i), 1'b0);
      check_state("break_hold", SBreak);
    end
    trig(1'b1, 5'd0, 1'b1);
    check_state("break_exit", SIdle);
    @(posedge clk_i);
    #1;
    check("frame_err_held", {31'd0, frame_err_o}, 32'd1);
    check_cnt("break", 2, 3, 5);

    // Start detection disabled
    rx_en_i = 1'b0;
    trig(1'b0, 5'd0, 1'b0);
    check_state("rx_en_off", SIdle);
    rx_en_i = 1'b1;

    // Reset while in CRC state, with a would-be transition pending
    crc_en_i = 1'b1;
    trig(1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 8; i++) trig(1'b1, 5'(i), i == 7);
    for (int i = 0; i < 3; i++) trig(1'b0, 5'(i), 1'b0);
    check_state("pre_reset_crc", SCrc);
    @(negedge clk_i);
    rst_i     = 1'b1;
    trigger_i = 1'b1;
    bit_cnt_i = 5'd7;
    #1;
    check("reset_mid_changed", {31'd0, changed_rx_state_o}, 32'd0);
    @(posedge clk_i);
    #1;
    rst_i     = 1'b0;
    trigger_i = 1'b0;
    crc_en_i  = 1'b0;
    check_state("reset_mid_state", SIdle);
    check("reset_mid_done", {31'd0, rx_done_o}, 32'd0);
    check("reset_mid_crc_en", {31'd0, crc_en_o}, 32'd0);
    repeat (2) @(posedge clk_i);
    #1;
    check_cnt("reset_mid", 0, 0, 5);

    // Counters were cleared by reset; four good frames saturate at 3
    frame(8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("sat1", 1, 0, 6);
    frame(8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(8'h11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("sat3", 3, 0, 8);
    frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("sat4", 3, 0, 9);

    // Standalone clear, then clear coincident with an increment
    @(negedge clk_i);
    stat_clr_i = 1'b1;
    @(posedge clk_i);
    #1;
    stat_clr_i = 1'b0;
    check_cnt("clr", 0, 0, 9);
    frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check_cnt("clr_wins", 0, 0, 10);
    frame(8'h66, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check_cnt("post_clr", 1, 0, 11);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
